// File: rtl/noc_pkg.sv
// Shared NoC definitions: module ids, ack id width, command opcodes, arbiter state.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents:
//   ID_W                    width of a module / ack id
//   MEM, SHA, AES, CTRL     module ids, which are also the arbiter requester indices
//   RD_KEY .. HASH_OP       opcodes used on the command ports
//   arb_state_t             bus arbiter FSM states
package noc_pkg;

    localparam int ID_W = 2;

    localparam logic [ID_W-1:0] MEM  = 2'd0;
    localparam logic [ID_W-1:0] SHA  = 2'd1;
    localparam logic [ID_W-1:0] AES  = 2'd2;
    localparam logic [ID_W-1:0] CTRL = 2'd3;

    localparam logic [1:0] RD_KEY  = 2'd0;
    localparam logic [1:0] RD_TEXT = 2'd1;
    localparam logic [1:0] WR_RES  = 2'd2;
    localparam logic [1:0] HASH_OP = 2'd3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin pick: returns the first set request at or after ptr, wrapping around.
// Latency: combinational, zero cycles.
// Backpressure: none; the result is valid whenever any_req is high.
//
// Ports:
//   req      in   NUM_REQ  request vector
//   ptr      in   IDX_W    index that has the highest priority this round
//   win      out  IDX_W    selected index (equals ptr when nothing is requested)
//   any_req  out  1        at least one request bit is set
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = noc_pkg::ID_W
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   win,
    output logic               any_req
);

    logic [IDX_W-1:0] idx;

    // Walk the requests starting at ptr; the first hit locks the result.
    always_comb begin
        win     = ptr;
        any_req = 1'b0;
        idx     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = IDX_W'((int'(ptr) + i) % NUM_REQ);
            if (!any_req && req[idx]) begin
                any_req = 1'b1;
                win     = idx;
            end
        end
    end

endmodule

// File: rtl/ack_bus_arbiter.sv
// Round-robin owner of the shared ack bus; registers the owner's ack and broadcasts it with its source id.
// Latency: grant 1 cycle after request in IDLE; ack broadcast 1 cycle after the owner's ack_send.
// Backpressure: no preemption; a grant ends on ack, request drop or timeout, then at least one IDLE cycle.
//
// Ports:
//   clk, rst        clock and asynchronous active-high reset
//   in_req          level request per requester (index = module id)
//   in_ack_send     1-cycle ack strobe per requester
//   in_ack_id       ack destination per requester, packed ID_W bits each
//   out_owned       one-hot ownership grant (zero when idle)
//   out_ack_valid   1-cycle broadcast strobe; out_ack_dest/out_ack_src hold otherwise
//   out_busy        a grant is active
//   out_timeout     1-cycle: grant revoked because no ack arrived in time
//   out_proto_err   1-cycle: ack_send seen from a requester that did not own the bus
module ack_bus_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      in_req,
    input  logic [NUM_REQ-1:0]      in_ack_send,
    input  logic [NUM_REQ*ID_W-1:0] in_ack_id,
    output logic [NUM_REQ-1:0]      out_owned,
    output logic                    out_ack_valid,
    output logic [ID_W-1:0]         out_ack_dest,
    output logic [ID_W-1:0]         out_ack_src,
    output logic                    out_busy,
    output logic                    out_timeout,
    output logic                    out_proto_err
);

    import noc_pkg::*;

    localparam int TMR_W = $clog2(TIMEOUT);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    arb_state_t          state_q, state_d;
    logic [ID_W-1:0]     win_q, win_d;
    logic [ID_W-1:0]     ptr_q, ptr_d;
    logic [TMR_W-1:0]    timer_q, timer_d;
    logic [NUM_REQ-1:0]  owned_d;
    logic                busy_d;
    logic                ack_valid_d;
    logic [ID_W-1:0]     ack_dest_d;
    logic [ID_W-1:0]     ack_src_d;
    logic                timeout_d;
    logic                proto_err_d;

    logic [ID_W-1:0]     pick_win;
    logic                pick_any;
    logic                release_grant;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (ID_W)
    ) u_pick (
        .req     (in_req),
        .ptr     (ptr_q),
        .win     (pick_win),
        .any_req (pick_any)
    );

    always_comb begin
        state_d       = state_q;
        win_d         = win_q;
        ptr_d         = ptr_q;
        timer_d       = timer_q;
        owned_d       = out_owned;
        busy_d        = out_busy;
        ack_valid_d   = 1'b0;
        ack_dest_d    = out_ack_dest;
        ack_src_d     = out_ack_src;
        timeout_d     = 1'b0;
        proto_err_d   = 1'b0;
        release_grant = 1'b0;

        case (state_q)
            IDLE: begin
                timer_d     = '0;
                // Nobody owns the bus, so any ack strobe is a protocol error.
                proto_err_d = |in_ack_send;
                if (pick_any) begin
                    state_d = GRANT;
                    win_d   = pick_win;
                    owned_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_win;
                    busy_d  = 1'b1;
                end
            end
            GRANT: begin
                timer_d     = timer_q + TMR_W'(1);
                proto_err_d = |(in_ack_send & ~out_owned);
                // Ack beats request drop, which beats timeout.
                if (in_ack_send[win_q]) begin
                    release_grant = 1'b1;
                    ack_valid_d   = 1'b1;
                    ack_dest_d    = in_ack_id[int'(win_q)*ID_W +: ID_W];
                    ack_src_d     = win_q;
                end else if (!in_req[win_q]) begin
                    release_grant = 1'b1;
                end else if (timer_q == TMR_LAST) begin
                    release_grant = 1'b1;
                    timeout_d     = 1'b1;
                end
                if (release_grant) begin
                    state_d = IDLE;
                    owned_d = '0;
                    busy_d  = 1'b0;
                    timer_d = '0;
                    ptr_d   = (int'(win_q) == NUM_REQ - 1) ? '0 : win_q + ID_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                owned_d = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            win_q         <= '0;
            ptr_q         <= '0;
            timer_q       <= '0;
            out_owned     <= '0;
            out_busy      <= 1'b0;
            out_ack_valid <= 1'b0;
            out_ack_dest  <= '0;
            out_ack_src   <= '0;
            out_timeout   <= 1'b0;
            out_proto_err <= 1'b0;
        end else begin
            state_q       <= state_d;
            win_q         <= win_d;
            ptr_q         <= ptr_d;
            timer_q       <= timer_d;
            out_owned     <= owned_d;
            out_busy      <= busy_d;
            out_ack_valid <= ack_valid_d;
            out_ack_dest  <= ack_dest_d;
            out_ack_src   <= ack_src_d;
            out_timeout   <= timeout_d;
            out_proto_err <= proto_err_d;
        end
    end

endmodule

// File: tb/tb_ack_bus_arbiter.sv
// Self-checking bench for ack_bus_arbiter: a reference model checked every cycle, plus directed literal checks.
module tb_ack_bus_arbiter;

    localparam int TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] in_req;
    logic [3:0] in_ack_send;
    logic [7:0] in_ack_id;
    logic [3:0] out_owned;
    logic       out_ack_valid;
    logic [1:0] out_ack_dest;
    logic [1:0] out_ack_src;
    logic       out_busy;
    logic       out_timeout;
    logic       out_proto_err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ack_bus_arbiter #(
        .NUM_REQ (4),
        .ID_W    (2),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_req        (in_req),
        .in_ack_send   (in_ack_send),
        .in_ack_id     (in_ack_id),
        .out_owned     (out_owned),
        .out_ack_valid (out_ack_valid),
        .out_ack_dest  (out_ack_dest),
        .out_ack_src   (out_ack_src),
        .out_busy      (out_busy),
        .out_timeout   (out_timeout),
        .out_proto_err (out_proto_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: who owns the bus, how long it has been held, and whose turn is next.
    int         m_owner = -1;
    int         m_ptr   = 0;
    int         m_held  = 0;
    logic [3:0] e_owned = '0;
    logic       e_busy  = 1'b0;
    logic       e_av    = 1'b0;
    logic       e_to    = 1'b0;
    logic       e_err   = 1'b0;
    logic [1:0] e_dest  = '0;
    logic [1:0] e_src   = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_owner = -1; m_ptr = 0; m_held = 0;
            e_owned = '0; e_busy = 1'b0; e_av = 1'b0; e_to = 1'b0;
            e_err = 1'b0; e_dest = '0; e_src = '0;
        end else begin
            e_av = 1'b0; e_to = 1'b0; e_err = 1'b0;
            if (m_owner < 0) begin
                e_err = (in_ack_send != 4'b0);
                for (int k = 0; k < 4; k++)
                    if (m_owner < 0 && in_req[(m_ptr + k) % 4]) begin
                        m_owner = (m_ptr + k) % 4;
                        m_held  = 0;
                    end
            end else begin
                bit done;
                done = 0;
                for (int j = 0; j < 4; j++)
                    if (j != m_owner && in_ack_send[j]) e_err = 1'b1;
                if (in_ack_send[m_owner]) begin
                    e_av   = 1'b1;
                    e_dest = in_ack_id[2*m_owner +: 2];
                    e_src  = 2'(m_owner);
                    done   = 1;
                end else if (!in_req[m_owner]) begin
                    done = 1;
                end else if (m_held == TIMEOUT - 1) begin
                    e_to = 1'b1;
                    done = 1;
                end else begin
                    m_held++;
                end
                if (done) begin
                    m_ptr   = (m_owner + 1) % 4;
                    m_owner = -1;
                end
            end
            e_owned = (m_owner < 0) ? 4'b0 : 4'(1 << m_owner);
            e_busy  = (m_owner >= 0);
        end
    end

    always @(negedge clk) begin
        chk("owned",     32'(out_owned),     32'(e_owned));
        chk("busy",      32'(out_busy),      32'(e_busy));
        chk("ack_valid", 32'(out_ack_valid), 32'(e_av));
        chk("ack_dest",  32'(out_ack_dest),  32'(e_dest));
        chk("ack_src",   32'(out_ack_src),   32'(e_src));
        chk("timeout",   32'(out_timeout),   32'(e_to));
        chk("proto_err", 32'(out_proto_err), 32'(e_err));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_req = '0; in_ack_send = '0; in_ack_id = '0;
        step();
        step();
        chk("rst_owned", 32'(out_owned), 32'h0);
        chk("rst_busy",  32'(out_busy),  32'h0);
        rst = 1'b0;
        step();

        // Single grant to SHA, ack to MEM three cycles later.
        in_req = 4'b0010;
        step();
        chk("t1_owned", 32'(out_owned), 32'h2);
        step();
        step();
        in_ack_send = 4'b0010; in_ack_id = 8'h00; in_req = 4'b0000;
        step();
        chk("t1_av",    32'(out_ack_valid), 32'h1);
        chk("t1_src",   32'(out_ack_src),   32'h1);
        chk("t1_dest",  32'(out_ack_dest),  32'h0);
        chk("t1_drop",  32'(out_owned),     32'h0);
        in_ack_send = '0;
        step();
        chk("t1_av_off", 32'(out_ack_valid), 32'h0);

        // Round-robin with everyone requesting; dest ids: r0->3, r1->0, r2->2, r3->1.
        pulse_reset();
        in_req = 4'b1111; in_ack_id = {2'd1, 2'd2, 2'd0, 2'd3};
        step();
        for (int n = 0; n < 5; n++) begin
            chk("t2_order", 32'(out_owned), 32'(1 << (n % 4)));
            in_ack_send = 4'(1 << (n % 4));
            step();
            chk("t2_gap",  32'(out_owned),   32'h0);
            chk("t2_src",  32'(out_ack_src), 32'(n % 4));
            in_ack_send = '0;
            if (n == 4) in_req = '0;
            step();
        end
        chk("t2_dest_hold", 32'(out_ack_dest), 32'h3);

        // Non-owner ack from CTRL while MEM owns; then an ack with nobody owning.
        in_req = 4'b0001;
        step();
        chk("t4_owned", 32'(out_owned), 32'h1);
        in_ack_send = 4'b1000;
        step();
        chk("t4_err",   32'(out_proto_err), 32'h1);
        chk("t4_keep",  32'(out_owned),     32'h1);
        in_ack_send = '0;
        step();
        chk("t4_err_off", 32'(out_proto_err), 32'h0);
        in_req = '0;
        step();
        in_ack_send = 4'b0100;
        step();
        chk("t4_idle_err", 32'(out_proto_err), 32'h1);
        in_ack_send = '0;
        step();

        // SHA acks and drops its request together; AES is next.
        in_req = 4'b0110; in_ack_id = 8'b00_00_11_00;
        step();
        chk("t5_owned", 32'(out_owned), 32'h2);
        in_req = 4'b0100; in_ack_send = 4'b0010;
        step();
        chk("t5_av",   32'(out_ack_valid), 32'h1);
        chk("t5_src",  32'(out_ack_src),   32'h1);
        chk("t5_dest", 32'(out_ack_dest),  32'h3);
        in_ack_send = '0;
        step();
        chk("t5_next", 32'(out_owned), 32'h4);

        // AES never acks: held for exactly TIMEOUT cycles.
        for (int k = 1; k < TIMEOUT; k++) step();
        chk("t3_still", 32'(out_owned), 32'h4);
        step();
        chk("t3_drop", 32'(out_owned),     32'h0);
        chk("t3_to",   32'(out_timeout),   32'h1);
        chk("t3_noav", 32'(out_ack_valid), 32'h0);
        in_req = '0;
        step();
        chk("t3_to_off", 32'(out_timeout), 32'h0);

        // Reset while AES owns: ownership drops without a clock edge.
        in_req = 4'b0100;
        step();
        chk("t6_owned", 32'(out_owned), 32'h4);
        rst = 1'b1;
        #1;
        chk("t6_async", 32'(out_owned), 32'h0);
        step();
        rst = 1'b0; in_req = 4'b1111;
        step();
        chk("t6_mem_first", 32'(out_owned), 32'h1);
        in_req = '0;
        step();

        // Mixed traffic, checked by the model each cycle.
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 7) == 0) in_req = 4'($urandom_range(0, 15));
            in_ack_id = 8'($urandom_range(0, 255));
            in_ack_send = ($urandom_range(0, 2) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'b0;
            step();
        end
        in_req = '0; in_ack_send = '0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
